// File: rtl/rv32i_single_cycle_core_if.sv
// rv32i_single_cycle_core_if: instruction ROM and data RAM bus of the single-cycle core
interface rv32i_single_cycle_core_if #(parameter int ROM_AW = 8, parameter int RAM_AW = 8);
  logic [31:0]       rom_data;
  logic [ROM_AW-1:0] rom_address;
  logic [31:0]       ram_data;
  logic [RAM_AW-1:0] ram_address;
  logic              ram_write_enable;
  logic [31:0]       ram_write_data;
  modport master(input rom_data, ram_data, output rom_address, ram_address, ram_write_enable, ram_write_data);
  modport slave(output rom_data, ram_data, input rom_address, ram_address, ram_write_enable, ram_write_data);
endinterface

// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I core (word loads/stores, halts on EBREAK)
// Define CPU_ERROR_CHECK_EN to drive the decoder/ALU error output.
module rv32i_single_cycle_core #(
  parameter int ROM_AW = 8,
  parameter int RAM_AW = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic       stop,
  output logic [1:0] error,
  rv32i_single_cycle_core_if.master bus
);
  localparam logic [3:0] ADD = 4'd0, SLL = 4'd1, SLT = 4'd2, SLTU = 4'd3, XOR = 4'd4,
                         SRL = 4'd5, OR = 4'd6, AND = 4'd7, SUB = 4'd8, SRA = 4'd13;
  localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  logic [ROM_AW-1:0] pc_q, pc_d, pc4;
  logic [31:0] rf_q [32];
  logic [31:0] inst, rs1_v, rs2_v, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] op_a, op_b, alu_res, wb_d;
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [3:0] alu_op;
  logic [1:0] a_sel, wb_sel;
  logic b_imm, rf_we, mem_we, br, jal, jalr, ill, brk, alu_err, cond, taken;
  assign inst  = bus.rom_data;
  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign f7    = inst[31:25];
  assign rs1_v = rf_q[rs1];
  assign rs2_v = rf_q[rs2];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  always_comb begin
    ill = 1'b0;
    brk = 1'b0;
    alu_op = ADD;
    a_sel = A_RS1;
    b_imm = 1'b1;
    imm = imm_i;
    wb_sel = WB_ALU;
    rf_we = 1'b0;
    mem_we = 1'b0;
    br = 1'b0;
    jal = 1'b0;
    jalr = 1'b0;
    case (opc)
      7'h37: begin a_sel = A_ZERO; imm = imm_u; rf_we = 1'b1; end
      7'h17: begin a_sel = A_PC; imm = imm_u; rf_we = 1'b1; end
      7'h6f: begin a_sel = A_PC; imm = imm_j; wb_sel = WB_PC4; rf_we = 1'b1; jal = 1'b1; end
      7'h67: begin ill = f3 != 3'd0; wb_sel = WB_PC4; rf_we = !ill; jalr = !ill; end
      7'h63: begin a_sel = A_PC; imm = imm_b; ill = f3[2:1] == 2'b01; br = !ill; end
      7'h03: begin ill = f3 != 3'd2; wb_sel = WB_MEM; rf_we = !ill; end
      7'h23: begin imm = imm_s; ill = f3 != 3'd2; mem_we = !ill; end
      7'h13: begin
        alu_op = {f3 == 3'd5 && f7[5], f3};
        ill = f3 == 3'd1 ? f7 != 7'h00 : f3 == 3'd5 ? !(f7 == 7'h00 || f7 == 7'h20) : 1'b0;
        rf_we = !ill;
      end
      7'h33: begin
        b_imm = 1'b0;
        alu_op = {f7[5], f3};
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        rf_we = !ill;
      end
      7'h73: begin brk = inst == 32'h0010_0073; ill = !brk; end
      default: ill = 1'b1;
    endcase
  end
  assign op_a = a_sel == A_RS1 ? rs1_v : a_sel == A_PC ? 32'(pc_q) : 32'd0;
  assign op_b = b_imm ? imm : rs2_v;
  always_comb begin
    alu_err = 1'b0;
    case (alu_op)
      ADD:     alu_res = op_a + op_b;
      SUB:     alu_res = op_a - op_b;
      AND:     alu_res = op_a & op_b;
      OR:      alu_res = op_a | op_b;
      XOR:     alu_res = op_a ^ op_b;
      SLL:     alu_res = op_a << op_b[4:0];
      SRL:     alu_res = op_a >> op_b[4:0];
      SRA:     alu_res = $signed(op_a) >>> op_b[4:0];
      SLT:     alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      SLTU:    alu_res = {31'd0, op_a < op_b};
      default: begin alu_res = 32'd0; alu_err = 1'b1; end
    endcase
  end
  // BNE/BGE/BGEU reuse EQ/LT/LTU with f3[0] inverting the outcome
  assign cond  = f3[2:1] == 2'b00 ? rs1_v == rs2_v : f3[2:1] == 2'b10 ? $signed(rs1_v) < $signed(rs2_v) : rs1_v < rs2_v;
  assign taken = br && (cond ^ f3[0]);
  assign pc4   = pc_q + ROM_AW'(4);
  assign pc_d  = jal || taken ? alu_res[ROM_AW-1:0] : jalr ? {alu_res[ROM_AW-1:1], 1'b0} : pc4;
  assign wb_d  = wb_sel == WB_MEM ? bus.ram_data : wb_sel == WB_PC4 ? 32'(pc4) : alu_res;
  assign stop  = reset && brk;
  assign bus.rom_address      = pc_q;
  assign bus.ram_address      = alu_res[RAM_AW-1:0];
  assign bus.ram_write_enable = reset && mem_we;
  assign bus.ram_write_data   = rs2_v;
`ifdef CPU_ERROR_CHECK_EN
  assign error = reset ? {ill, alu_err} : 2'b00;
`else
  assign error = {ill, alu_err} & 2'b00;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (!brk) begin
      pc_q <= pc_d;
      if (rf_we && rd != 5'd0) rf_q[rd] <= wb_d;
    end
  end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: directed programs with hand-computed register and memory results
module tb_rv32i_single_cycle_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stop;
  logic [1:0] error;
  logic [31:0] rom [64];
  logic [31:0] ram [64] = '{default: 32'd0};
  int tests = 0;
  int fails = 0;
`ifdef CPU_ERROR_CHECK_EN
  localparam logic [1:0] ILL = 2'b10;
`else
  localparam logic [1:0] ILL = 2'b00;
`endif
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  rv32i_single_cycle_core_if bus();
  rv32i_single_cycle_core dut(.clk(clk), .reset(reset), .stop(stop), .error(error), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.rom_data = rom[bus.rom_address[7:2]];
  always_comb bus.ram_data = ram[bus.ram_address[7:2]];
  always @(posedge clk) if (bus.ram_write_enable) ram[bus.ram_address[7:2]] <= bus.ram_write_data;

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_to(input string tag, input int addr, input int budget);
    for (int n = 0; n < budget && int'(bus.rom_address) != addr; n++) @(negedge clk);
    check(tag, 32'(bus.rom_address), addr);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = EBREAK;
    rom[0]  = enc_i(10, 0, 0, 1, 7'h13);
    rom[1]  = enc_i(50, 1, 0, 1, 7'h13);
    rom[2]  = enc_i(5, 1, 0, 2, 7'h13);
    rom[3]  = enc_u(20'h7FFFF, 11, 7'h17);
    rom[4]  = enc_i(-1, 2, 0, 2, 7'h13);
    rom[5]  = enc_b(-4, 2, 1, 3'd4);
    rom[6]  = enc_b(8, 1, 2, 3'd0);
    rom[7]  = enc_i(1, 0, 0, 13, 7'h13);
    rom[8]  = enc_i(1, 1, 0, 3, 7'h13);
    rom[9]  = enc_i(2, 1, 0, 4, 7'h13);
    rom[10] = enc_r(7'h20, 1, 4, 0, 5);
    rom[11] = enc_i(0, 0, 0, 0, 7'h13);
    rom[12] = enc_j(8, 8);
    rom[13] = enc_j(16, 0);
    rom[14] = enc_u(20'h0, 12, 7'h17);
    rom[15] = enc_i(-4, 12, 0, 11, 7'h67);
    rom[16] = enc_i(3, 0, 0, 13, 7'h13);
    rom[17] = enc_r(7'h00, 2, 1, 7, 6);
    rom[18] = enc_i(55, 0, 0, 7, 7'h13);
    rom[19] = enc_s(-32, 1, 1);
    rom[20] = enc_i(28, 0, 2, 9, 7'h03);
    rom[21] = enc_u(20'hFFFFF, 10, 7'h37);
    rom[22] = enc_i(32'hFFE, 0, 4, 10, 7'h13);
    rom[23] = enc_s(0, 10, 0);
    rom[24] = EBREAK;
    @(negedge clk);
    check("rst_pc", 32'(bus.rom_address), 0);
    check("rst_err", 32'(error), 0);
    check("rst_stop", 32'(stop), 0);
    check("rst_we", 32'(bus.ram_write_enable), 0);
    @(negedge clk);
    reset = 1'b1;
    check("first_fetch", 32'(bus.rom_address), 0);
    run_to("loop_exit", 24, 100);
    check("x1", dut.rf_q[1], 60);
    check("x2", dut.rf_q[2], 60);
    check("auipc_x11", dut.rf_q[11], 32'h7FFFF00C);
    run_to("halt_pc", 96, 100);
    check("stop", 32'(stop), 1);
    check("x3", dut.rf_q[3], 61);
    check("x4", dut.rf_q[4], 62);
    check("x5", dut.rf_q[5], 2);
    check("x8", dut.rf_q[8], 52);
    check("x12", dut.rf_q[12], 56);
    check("jalr_x11", dut.rf_q[11], 64);
    check("x13_skipped", dut.rf_q[13], 0);
    check("x6", dut.rf_q[6], 60);
    check("x7", dut.rf_q[7], 55);
    check("ram28", ram[7], 60);
    check("x9", dut.rf_q[9], 60);
    check("x10", dut.rf_q[10], 32'hFFFFFFFE);
    check("ram0", ram[0], 32'hFFFFFFFE);
    repeat (3) @(negedge clk);
    check("frozen_pc", 32'(bus.rom_address), 96);
    check("frozen_stop", 32'(stop), 1);
    reset = 1'b0;
    #1 check("stop_in_rst", 32'(stop), 0);
    @(negedge clk);
    check("mid_rst_pc", 32'(bus.rom_address), 0);
    check("mid_rst_x10", dut.rf_q[10], 0);
    for (int i = 0; i < 64; i++) rom[i] = EBREAK;
    rom[0]  = enc_i(0, 0, 0, 14, 7'h03);
    rom[1]  = 32'h0000_0073;
    rom[2]  = enc_i(32'h401, 0, 1, 15, 7'h13);
    rom[3]  = enc_i(7, 0, 0, 1, 7'h13);
    rom[4]  = enc_i(5, 0, 0, 0, 7'h13);
    rom[5]  = enc_r(7'h00, 0, 0, 0, 1);
    rom[6]  = enc_i(-8, 0, 0, 17, 7'h13);
    rom[7]  = enc_i(32'h401, 17, 5, 18, 7'h13);
    rom[8]  = enc_i(28, 17, 5, 19, 7'h13);
    rom[9]  = enc_r(7'h00, 17, 0, 3, 20);
    rom[10] = enc_r(7'h00, 0, 17, 2, 21);
    rom[11] = enc_r(7'h00, 19, 19, 1, 23);
    rom[12] = enc_b(8, 19, 17, 3'd7);
    rom[13] = enc_i(1, 0, 0, 24, 7'h13);
    rom[14] = enc_b(8, 0, 0, 3'd1);
    rom[15] = enc_i(9, 0, 0, 25, 7'h13);
    rom[16] = EBREAK;
    reset = 1'b1;
    #1 check("lb_err", 32'(error), 32'(ILL));
    check("lb_we", 32'(bus.ram_write_enable), 0);
    @(negedge clk);
    check("lb_pc4", 32'(bus.rom_address), 4);
    check("ecall_err", 32'(error), 32'(ILL));
    @(negedge clk);
    check("ecall_pc4", 32'(bus.rom_address), 8);
    check("slli_bad_err", 32'(error), 32'(ILL));
    @(negedge clk);
    check("legal_err", 32'(error), 0);
    run_to("halt2", 64, 100);
    check("stop2", 32'(stop), 1);
    check("x14_ill", dut.rf_q[14], 0);
    check("x15_ill", dut.rf_q[15], 0);
    check("ram0_kept", ram[0], 32'hFFFFFFFE);
    check("x0", dut.rf_q[0], 0);
    check("x1_zero", dut.rf_q[1], 0);
    check("srai", dut.rf_q[18], 32'hFFFFFFFC);
    check("srli", dut.rf_q[19], 32'hF);
    check("sltu", dut.rf_q[20], 1);
    check("slt", dut.rf_q[21], 1);
    check("sll", dut.rf_q[23], 32'h78000);
    check("bgeu_skip", dut.rf_q[24], 0);
    check("bne_fall", dut.rf_q[25], 9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32i_single_cycle_core.md
# rv32i_single_cycle_core

Single-cycle RV32I integer core: instruction decoder, ALU, branch comparator, 32×32 register file and program counter in one block. It fetches one word per cycle from an external combinational ROM and performs word-only loads and stores on an external RAM with a combinational read port. It sits between the instruction ROM and the data RAM. Execution halts on EBREAK.

## Interface
- `ROM_AW`, 8: ROM byte-address width.
- `RAM_AW`, 8: RAM byte-address width.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `stop` output 1: current instruction is EBREAK.
- `error` output 2: bit 1 = decoder error, bit 0 = ALU error.
- `rom_data` input 32: instruction at `rom_address`.
- `rom_address` output ROM_AW: PC as a byte address.
- `ram_data` input 32: combinational read data at `ram_address`.
- `ram_address` output RAM_AW: byte address, taken from ALU result bits [RAM_AW-1:0].
- `ram_write_enable` output 1: store strobe for the current cycle.
- `ram_write_data` output 32: value of rs2.

## Operation
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, all OP-IMM, all OP, EBREAK.
- Illegal instructions:
  - Includes LB/LH/LBU/LHU/SB/SH, FENCE, ECALL, unknown opcode/funct3/funct7, and shift-imm with bad imm[11:5].
  - Set decoder error.
  - Behave as NOP: no register write, no store, PC+4.
- Immediates are sign-extended per the I/S/B/U/J formats.
- ALU operand A is rs1, PC or 0. Operand B is rs2 or immediate.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Shift amount is B[4:0].
- An undefined internal ALU op code sets ALU error and gives result 0.
- Comparator always compares rs1 against rs2. It supports EQ, LT and LTU; BNE, BGE and BGEU use the negated result.
- Branch and JAL target = PC + imm, computed by the ALU. JALR target = (rs1 + imm) with bit 0 cleared.
- Register write-back selects ALU result, `ram_data` (LW) or PC+4 (JAL/JALR). No write for branches, stores, EBREAK or illegal instructions.
- x0 reads 0; writes to x0 are discarded.
- Memory:
  - LW/SW address = rs1 + imm.
  - `ram_write_enable` = 1 only for SW.
  - Low address bits are passed through without alignment checking.

## Timing
- Single cycle: decode, ALU, compare and the RAM read are combinational from `rom_data`.
- PC and the register-file write update on the next rising edge.
- Reset (`reset`=0 at a rising edge):
  - PC and all 32 registers become 0.
  - While `reset`=0: `stop`, `error` and `ram_write_enable` are forced to 0, and no register write occurs.
  - `rom_address` = 0 from the first rising edge with `reset`=0 onward.
- Release: the first instruction (address 0) executes in the first cycle with `reset`=1.
- Reset asserted mid-program: at that edge, state returns to PC=0 with registers cleared, regardless of the current instruction.
- EBREAK:
  - `stop`=1 combinationally.
  - PC and registers hold while `stop`=1, so the core stays at EBREAK until reset.
- `error` is combinational for the current instruction; the bench samples it before the edge.
- PC wraps modulo 2^ROM_AW.

## Configuration
- `CPU_ERROR_CHECK_EN` defined: `error` is driven as specified above.
- `CPU_ERROR_CHECK_EN` undefined:
  - `error` is tied to 2'b00.
  - Illegal instructions still execute as NOP.
  - Undefined ALU ops still yield 0.

## Test plan
- Hold reset low for 2 cycles, then release. Required: `rom_address`=0 and `error`=0 during reset; first fetch is from 0.
- Arithmetic, AUIPC and BLT loop. Program: ADDI x1,x0,10; ADDI x1,x1,50; ADDI x2,x1,5; AUIPC x11,0x7FFFF000 at PC 12; ADDI x2,x2,-1; BLT x1,x2,-4. Required: loop exits with x2=60; x11=0x7FFFF00C.
- Branch, jump and load/store sequence: BEQ x2,x1,+8 skips a NOP; x3=61; x4=62; SUB gives x5=2; JAL x8,+8 at PC 48; AUIPC x12 at PC 56; JALR x11,x12,-4; JAL x0,+16; AND x6=60; ADDI x7=55; SW x1,-32(x1); LW x9,0x1c(x0). Required:
  - x8=52, x12=56, x11=64.
  - x6=60, x7=55.
  - RAM[28]=60, x9=60.
- LUI x10,0xFFFFF000, then XORI x10,x0,0xFFE, then SW x10,0(x0), then EBREAK at PC 96. Required:
  - x10=0xFFFFFFFE and RAM[0]=0xFFFFFFFE.
  - `stop`=1, with PC frozen at 96.
- Issue LB, then ECALL. Required: `error`=2'b10 for each; no register or RAM change; PC advances by 4. With `CPU_ERROR_CHECK_EN` undefined, `error` stays 0.
- ADDI x0,x0,5, then ADD x1,x0,x0. Required: x1=0.
